// File: rtl/mul_div_if.sv
// mul_div_if: request/result bundle between the EX stage and mul_div_unit.
// Ports: start_in/op_in/a_in/b_in/cancel_in carry the request; busy_out,
// done_out, div_zero_out, hi_out, lo_out carry status and the HI/LO result.
interface mul_div_if #(parameter int WIDTH = 32);
    logic             start_in;
    logic             cancel_in;
    logic [1:0]       op_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic             div_zero_out;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    modport master (output start_in, cancel_in, op_in, a_in, b_in,
                    input  busy_out, done_out, div_zero_out, hi_out, lo_out);
    modport slave  (input  start_in, cancel_in, op_in, a_in, b_in,
                    output busy_out, done_out, div_zero_out, hi_out, lo_out);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative one-bit-per-cycle MULTU/MULT/DIVU/DIV with HI/LO registers.
// Ports: clk, rst (async, active-high), bus (mul_div_if.slave: request in,
// busy/done/div_zero status and HI/LO out). Define MULDIV_SIGNED_EN to enable
// signed MULT/DIV; otherwise op[0] is ignored and all ops are unsigned.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    mul_div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               div_q, div_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0]   a_mag, b_mag, mul_hi, mul_lo, div_hi, div_lo;
    logic [WIDTH:0]     sum, sh, diff;
    logic               accept;
`ifdef MULDIV_SIGNED_EN
    logic               sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d;
    logic [2*WIDTH-1:0] prod;
    assign a_mag = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    assign prod = neg_q ? -acc_q : acc_q;
    assign {mul_hi, mul_lo} = prod;
    assign div_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign div_hi = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
    assign a_mag = a_q;
    assign b_mag = b_q;
    assign {mul_hi, mul_lo} = acc_q;
    assign div_lo = acc_q[WIDTH-1:0];
    assign div_hi = acc_q[2*WIDTH-1:WIDTH];
`endif
    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    // Divide: acc = {remainder, dividend->quotient}; restoring trial subtract.
    assign sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff = sh - {1'b0, m_q};
    assign accept = bus.start_in && !bus.cancel_in && (state_q == IDLE || state_q == DONE);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        a_d = a_q;
        b_d = b_q;
        m_d = m_q;
        div_d = div_q;
        acc_d = acc_q;
        hi_d = hi_q;
        lo_d = lo_q;
        dz_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn_d = sgn_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
`endif
        case (state_q)
            IDLE: state_d = IDLE;
            PREP: begin
                state_d = CALC;
                cnt_d = CNT_W'(WIDTH - 1);
                m_d = div_q ? b_mag : a_mag;
                acc_d = {{WIDTH{1'b0}}, div_q ? a_mag : b_mag};
`ifdef MULDIV_SIGNED_EN
                neg_d = (sgn_q & a_q[WIDTH-1]) ^ (sgn_q & b_q[WIDTH-1]);
                rneg_d = sgn_q & a_q[WIDTH-1];
`endif
            end
            CALC: begin
                acc_d = !div_q ? {sum, acc_q[WIDTH-1:1]}
                      : diff[WIDTH] ? {sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                      : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIX : CALC;
            end
            FIX: begin
                state_d = DONE;
                dz_d = div_q && (b_q == '0);
                hi_d = !div_q ? mul_hi : (b_q == '0) ? a_q : div_hi;
                lo_d = !div_q ? mul_lo : (b_q == '0) ? '1 : div_lo;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = PREP;
            a_d = bus.a_in;
            b_d = bus.b_in;
            div_d = bus.op_in[1];
`ifdef MULDIV_SIGNED_EN
            sgn_d = bus.op_in[0];
`endif
        end
        if (bus.cancel_in && state_q != IDLE) begin
            state_d = IDLE;
            hi_d = hi_q;
            lo_d = lo_q;
            dz_d = 1'b0;
        end
        busy_d = (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
            div_q <= 1'b0;
            acc_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            m_q <= m_d;
            div_q <= div_d;
            acc_q <= acc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q <= dz_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q <= sgn_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
`endif
        end
    end
    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
    assign bus.div_zero_out = dz_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, the next-generation arithmetic block for the pipelined CPU. It sits beside the EX-stage ALU. It accepts one operation per start pulse and computes one bit per cycle. While it works, it raises `busy_out`, which the hazard logic uses to stall IF/ID/EX. It returns a WIDTH-bit HI/LO pair with a one-cycle `done_out` pulse.

## Interface
- `WIDTH`, 32, operand and HI/LO width; legal range 4..64.
- `CNT_W`, `$clog2(WIDTH)+1`, iteration counter width; derived, not overridden.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_in`  in  1  request; sampled only while `busy_out`=0.
- `op_in`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start_in`.
- `a_in`  in  WIDTH  multiplicand / dividend; sampled with `start_in`.
- `b_in`  in  WIDTH  multiplier / divisor; sampled with `start_in`.
- `cancel_in`  in  1  pipeline flush; aborts an in-flight operation.
- `busy_out`  out  1  operation in progress.
- `done_out`  out  1  one-cycle pulse; HI/LO updated this cycle.
- `div_zero_out`  out  1  pulses with `done_out` when a divide had `b`=0.
- `hi_out`  out  WIDTH  HI register (product upper half / remainder).
- `lo_out`  out  WIDTH  LO register (product lower half / quotient).

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - PREP: latch operands. For signed ops with `MULDIV_SIGNED_EN`, take magnitudes and record the result sign(s).
  - CALC: WIDTH iterations, counted down from WIDTH-1 to 0.
  - FIX: apply sign correction; write HI/LO.
  - DONE: pulse `done_out`; return to IDLE.
- Transitions:
  - IDLE→PREP on `start_in`=1 and `cancel_in`=0.
  - PREP→CALC unconditionally.
  - CALC→FIX when the counter reaches 0.
  - FIX→DONE unconditionally.
  - DONE→IDLE, or DONE→PREP if `start_in`=1 in DONE (back-to-back).
- Multiply: shift-add on a 2·WIDTH accumulator. Product is {HI,LO}, exact modulo 2^(2·WIDTH).
- Divide: restoring, one quotient bit per iteration. LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = `a_in` unchanged, `div_zero_out`=1 with `done_out`.
- Signed overflow (most-negative / −1): LO = most-negative value, HI=0, no `div_zero_out`.
- HI/LO hold their value between operations. They change only in FIX of a non-cancelled operation.
- `cancel_in`=1 in any state other than IDLE:
  - Next state is IDLE.
  - HI/LO are not written.
  - No `done_out` pulse.
- `cancel_in` and `start_in` in the same cycle: cancel wins, start is dropped.
- `start_in` while `busy_out`=1 is ignored; no queueing.
- Reset asserted at any time, including mid-CALC:
  - Immediately forces IDLE, HI=LO=0, counter=0.
  - `busy_out`=`done_out`=`div_zero_out`=0.

## Timing
- Cycle 0: `start_in` sampled at the rising edge ending the cycle.
- Cycle 1: PREP. `busy_out` is registered, so it is high from cycle 1.
- Cycles 2..WIDTH+1: CALC.
- Cycle WIDTH+2: FIX.
- Cycle WIDTH+3: DONE.
  - `done_out`=1 and `busy_out`=0.
  - `hi_out`/`lo_out` already show the new result.
- Latency from start to done is WIDTH+3 cycles; 35 for WIDTH=32.
- Throughput: one operation per WIDTH+3 cycles when back-to-back starts are issued in DONE.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: `busy_out`=0, `done_out`=0, `div_zero_out`=0, `hi_out`=0, `lo_out`=0.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV perform two's-complement signed arithmetic as above.
  - PREP and FIX apply magnitude conversion and sign correction.
- Not defined:
  - `op_in[0]` is ignored, so MULT behaves as MULTU and DIV as DIVU.
  - Signed-overflow special case does not exist.
  - Sign logic is removed.
  - PREP and FIX states remain, so latency is unchanged at WIDTH+3.

## Test plan
- MULTU (WIDTH=32), a=0xFFFFFFFF, b=0x00000002, start at cycle 0 -> `busy_out` high cycles 1–34; `done_out` only at cycle 35; HI=0x00000001, LO=0xFFFFFFFE.
- MULT, a=0xFFFFFFFD (−3), b=5 -> with macro: HI=0xFFFFFFFF, LO=0xFFFFFFF1; without macro: HI=0x00000004, LO=0xFFFFFFF1.
- DIV with macro: a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, `div_zero_out`=0.
- DIVU, a=10, b=0 -> LO=0xFFFFFFFF, HI=0x0000000A, `div_zero_out`=1 in the same cycle as `done_out`.
- Preload HI=1/LO=2. Start MULTU 3×4, assert `cancel_in` at cycle 10 -> `busy_out`=0 at cycle 11; no `done_out`; HI/LO stay 1/2. Start again at cycle 11 -> HI=0, LO=12 at cycle 11+35.
- Assert `rst` asynchronously mid-CALC (cycle 15, between edges) -> all outputs 0 before the next edge. `start_in` held through reset release is accepted on the first edge after release.
